// File: rtl/serial_target_port_fifo.sv
// serial_target_port_fifo
//   Target-side port of the serial bus. It deserialises LSB-first address and write-data frames
//   into parallel transfers, and serialises target read data from a TX FIFO back onto the bus.
//   Optional macro SERIAL_PARITY_EN adds one trailing even-parity bit to every frame.
// Ports
//   clk, rst                       clock, asynchronous active-high reset
//   target_data_out[_valid/_ready] read-data push interface into the TX FIFO
//   target_rw/ready/ack            target status, copied to bus_target_* combinationally
//   bus_data_in[_valid], bus_mode  serial RX bit, qualifier, 1 = data frame / 0 = address frame
//   bus_data_out[_valid]           serial TX bit, LSB first
//   target_addr_in[_valid]         received address, held; 1-cycle valid pulse
//   target_data_in[_valid]         received write data, held (0 on read delivery); 1-cycle pulse
//   rx_err, parity_err             1-cycle error pulses
module serial_target_port_fifo #(
   parameter int unsigned ADDR_WIDTH    = 16,
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned TX_FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] target_data_out,
   input  logic                  target_data_out_valid,
   output logic                  target_data_out_ready,
   input  logic                  target_rw,
   input  logic                  target_ready,
   input  logic                  target_ack,
   output logic                  bus_target_rw,
   output logic                  bus_target_ready,
   output logic                  bus_target_ack,
   input  logic                  bus_data_in,
   input  logic                  bus_data_in_valid,
   input  logic                  bus_mode,
   output logic                  bus_data_out,
   output logic                  bus_data_out_valid,
   output logic [ADDR_WIDTH-1:0] target_addr_in,
   output logic                  target_addr_in_valid,
   output logic [DATA_WIDTH-1:0] target_data_in,
   output logic                  target_data_in_valid,
   output logic                  rx_err,
   output logic                  parity_err
);

`ifdef SERIAL_PARITY_EN
   localparam int unsigned Par = 1;
`else
   localparam int unsigned Par = 0;
`endif
   localparam int unsigned Afl = ADDR_WIDTH + Par;  // RX address frame length
   localparam int unsigned Dfl = DATA_WIDTH + Par;  // RX/TX data frame length
   localparam int unsigned Acw = $clog2(Afl);
   localparam int unsigned Dcw = $clog2(Dfl);
   localparam int unsigned Pw  = $clog2(TX_FIFO_DEPTH);
   localparam int unsigned Cw  = Pw + 1;
   localparam logic [Acw-1:0] ALast = Acw'(Afl - 1);
   localparam logic [Dcw-1:0] DLast = Dcw'(Dfl - 1);

   typedef enum logic [1:0] {StIdle, StLoad, StShift} tx_state_e;

   assign bus_target_rw    = target_rw;
   assign bus_target_ready = target_ready;
   assign bus_target_ack   = target_ack;

   // ---------------- TX FIFO ----------------
   logic [DATA_WIDTH-1:0] mem_q [TX_FIFO_DEPTH];
   logic [Pw-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [Cw-1:0]         count_q, count_d;
   logic                  fifo_full, fifo_empty, push, pop;
   tx_state_e             st_q;
   logic [Dfl-1:0]        sh_q, tx_frame;
   logic [Dcw-1:0]        tcnt_q;
   logic                  tx_valid_q;

   assign fifo_full             = (count_q == Cw'(TX_FIFO_DEPTH));
   assign fifo_empty            = (count_q == '0);
   assign target_data_out_ready = !fifo_full;
   assign push                  = target_data_out_valid && !fifo_full;
   assign pop                   = (st_q == StLoad);  // LOAD is only entered with data present

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + Pw'(1) : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + Pw'(1) : rd_ptr_q;
      count_d  = count_q + {{Pw{1'b0}}, push} - {{Pw{1'b0}}, pop};
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= target_data_out;
   end

`ifdef SERIAL_PARITY_EN
   assign tx_frame = {^mem_q[rd_ptr_q], mem_q[rd_ptr_q]};
`else
   assign tx_frame = mem_q[rd_ptr_q];
`endif

   // ---------------- TX serialiser ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q       <= StIdle;
         sh_q       <= '0;
         tcnt_q     <= '0;
         tx_valid_q <= 1'b0;
      end else begin
         unique case (st_q)
            StIdle: if (!fifo_empty) st_q <= StLoad;
            StLoad: begin
               sh_q       <= tx_frame;
               tcnt_q     <= '0;
               tx_valid_q <= 1'b1;
               st_q       <= StShift;
            end
            StShift: begin
               if (tcnt_q == DLast) begin
                  sh_q       <= '0;
                  tx_valid_q <= 1'b0;  // the one gap cycle between words
                  st_q       <= fifo_empty ? StIdle : StLoad;
               end else begin
                  sh_q   <= sh_q >> 1;
                  tcnt_q <= tcnt_q + Dcw'(1);
               end
            end
            default: st_q <= StIdle;
         endcase
      end
   end

   assign bus_data_out       = sh_q[0];
   assign bus_data_out_valid = tx_valid_q;

   // ---------------- RX deserialiser ----------------
   logic [Acw-1:0]        addr_cnt_q, addr_cnt_d;
   logic [Dcw-1:0]        data_cnt_q, data_cnt_d;
   logic [ADDR_WIDTH-1:0] addr_buf_q, addr_buf_d, addr_out_q, addr_out_d;
   logic [DATA_WIDTH-1:0] data_buf_q, data_buf_d, data_out_q, data_out_d;
   logic pending_q, pending_d, dlv_rd_q, dlv_rd_d, dlv_wr_q, dlv_wr_d, perr_q, perr_d;
   logic addr_valid_q, addr_valid_d, data_valid_q, data_valid_d;
   logic rx_err_q, rx_err_d, parity_err_q, parity_err_d;
   logic bit_in, wr_open, a_par_bad, d_par_bad;

`ifdef SERIAL_PARITY_EN
   assign a_par_bad = (^addr_buf_q) != bus_data_in;
   assign d_par_bad = (^data_buf_q) != bus_data_in;
`else
   assign a_par_bad = 1'b0;
   assign d_par_bad = 1'b0;
`endif

   assign bit_in  = bus_data_in_valid && (st_q == StIdle);
   // A write address stays pending through its delivery edge, but that edge may already
   // start a new address frame.
   assign wr_open = pending_q && !dlv_wr_q;

   always_comb begin
      addr_cnt_d   = addr_cnt_q;
      data_cnt_d   = data_cnt_q;
      addr_buf_d   = addr_buf_q;
      data_buf_d   = data_buf_q;
      addr_out_d   = addr_out_q;
      data_out_d   = data_out_q;
      pending_d    = pending_q;
      dlv_rd_d     = 1'b0;
      dlv_wr_d     = 1'b0;
      perr_d       = 1'b0;
      addr_valid_d = 1'b0;
      data_valid_d = 1'b0;
      rx_err_d     = 1'b0;
      parity_err_d = perr_q;

      if (dlv_rd_q) begin
         addr_out_d   = addr_buf_q;
         data_out_d   = '0;
         addr_valid_d = 1'b1;
      end
      if (dlv_wr_q) begin
         addr_out_d   = addr_buf_q;
         data_out_d   = data_buf_q;
         addr_valid_d = 1'b1;
         data_valid_d = 1'b1;
         pending_d    = 1'b0;
      end

      if (bit_in && !bus_mode) begin
         if (wr_open) begin
            rx_err_d = 1'b1;
         end else begin
            for (int i = 0; i < ADDR_WIDTH; i++) begin
               if (int'(addr_cnt_q) == i) addr_buf_d[i] = bus_data_in;
            end
            if (addr_cnt_q == ALast) begin
               addr_cnt_d = '0;
               if (a_par_bad)      perr_d    = 1'b1;
               else if (target_rw) pending_d = 1'b1;
               else                dlv_rd_d  = 1'b1;
            end else begin
               addr_cnt_d = addr_cnt_q + Acw'(1);
            end
         end
      end else if (bit_in && bus_mode) begin
         if (addr_cnt_q != '0) begin
            addr_cnt_d = '0;  // abort the partial address
            rx_err_d   = 1'b1;
         end else if (!wr_open) begin
            rx_err_d = 1'b1;
         end else begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
               if (int'(data_cnt_q) == i) data_buf_d[i] = bus_data_in;
            end
            if (data_cnt_q == DLast) begin
               data_cnt_d = '0;
               if (d_par_bad) begin
                  perr_d    = 1'b1;
                  pending_d = 1'b0;
               end else begin
                  dlv_wr_d = 1'b1;
               end
            end else begin
               data_cnt_d = data_cnt_q + Dcw'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         addr_cnt_q   <= '0;
         data_cnt_q   <= '0;
         addr_buf_q   <= '0;
         data_buf_q   <= '0;
         addr_out_q   <= '0;
         data_out_q   <= '0;
         pending_q    <= 1'b0;
         dlv_rd_q     <= 1'b0;
         dlv_wr_q     <= 1'b0;
         perr_q       <= 1'b0;
         addr_valid_q <= 1'b0;
         data_valid_q <= 1'b0;
         rx_err_q     <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         addr_cnt_q   <= addr_cnt_d;
         data_cnt_q   <= data_cnt_d;
         addr_buf_q   <= addr_buf_d;
         data_buf_q   <= data_buf_d;
         addr_out_q   <= addr_out_d;
         data_out_q   <= data_out_d;
         pending_q    <= pending_d;
         dlv_rd_q     <= dlv_rd_d;
         dlv_wr_q     <= dlv_wr_d;
         perr_q       <= perr_d;
         addr_valid_q <= addr_valid_d;
         data_valid_q <= data_valid_d;
         rx_err_q     <= rx_err_d;
         parity_err_q <= parity_err_d;
      end
   end

   assign target_addr_in       = addr_out_q;
   assign target_addr_in_valid = addr_valid_q;
   assign target_data_in       = data_out_q;
   assign target_data_in_valid = data_valid_q;
   assign rx_err               = rx_err_q;
   assign parity_err           = parity_err_q;

endmodule

// File: tb/tb_serial_target_port_fifo.sv
// Testbench for serial_target_port_fifo (default widths 16/8, depth 4).
module tb_serial_target_port_fifo;
   localparam int AW = 16;
   localparam int DW = 8;
`ifdef SERIAL_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int TFL = DW + PAR;

   logic clk = 1'b0, rst = 1'b1;
   logic [DW-1:0] target_data_out = '0;
   logic target_data_out_valid = 1'b0, target_data_out_ready;
   logic target_rw = 1'b0, target_ready = 1'b0, target_ack = 1'b0;
   logic bus_target_rw, bus_target_ready, bus_target_ack;
   logic bus_data_in = 1'b0, bus_data_in_valid = 1'b0, bus_mode = 1'b0;
   logic bus_data_out, bus_data_out_valid;
   logic [AW-1:0] target_addr_in;
   logic target_addr_in_valid;
   logic [DW-1:0] target_data_in;
   logic target_data_in_valid, rx_err, parity_err;

   serial_target_port_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TX_FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .target_data_out(target_data_out), .target_data_out_valid(target_data_out_valid),
      .target_data_out_ready(target_data_out_ready),
      .target_rw(target_rw), .target_ready(target_ready), .target_ack(target_ack),
      .bus_target_rw(bus_target_rw), .bus_target_ready(bus_target_ready),
      .bus_target_ack(bus_target_ack),
      .bus_data_in(bus_data_in), .bus_data_in_valid(bus_data_in_valid), .bus_mode(bus_mode),
      .bus_data_out(bus_data_out), .bus_data_out_valid(bus_data_out_valid),
      .target_addr_in(target_addr_in), .target_addr_in_valid(target_addr_in_valid),
      .target_data_in(target_data_in), .target_data_in_valid(target_data_in_valid),
      .rx_err(rx_err), .parity_err(parity_err)
   );

   always #5 clk = ~clk;

   int vec_cnt = 0, miscmp = 0, cyc = 0;
   int av_cnt = 0, rxe_cnt = 0, pe_cnt = 0;
   logic stall_seen = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Pulse counters, sampled mid-cycle
   always @(negedge clk) begin
      av_cnt  += int'(target_addr_in_valid);
      rxe_cnt += int'(rx_err);
      pe_cnt  += int'(parity_err);
   end

   // TX bus monitor: rebuilds words and records gaps / first-bit cycle per word
   logic [TFL-1:0] txw_q[$];
   int gap_q[$], fb_cyc_q[$];
   logic [TFL-1:0] mb;
   int mcnt = 0, gap_run = 0, tx_broken = 0;
   always @(negedge clk) begin
      if (rst) begin
         mcnt = 0;
         gap_run = 0;
      end else if (bus_data_out_valid) begin
         if (mcnt == 0) begin
            gap_q.push_back(gap_run);
            fb_cyc_q.push_back(cyc);
         end
         mb[mcnt] = bus_data_out;
         mcnt++;
         gap_run = 0;
         if (mcnt == TFL) begin
            txw_q.push_back(mb);
            mcnt = 0;
         end
      end else begin
         if (mcnt != 0) tx_broken++;
         mcnt = 0;
         gap_run++;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         miscmp++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] afr(input logic [AW-1:0] a);
      logic [31:0] r;
      r = 32'(a);
      if (PAR != 0) r[AW] = ^a;
      return r;
   endfunction

   function automatic logic [31:0] dfr(input logic [DW-1:0] d);
      logic [31:0] r;
      r = 32'(d);
      if (PAR != 0) r[DW] = ^d;
      return r;
   endfunction

   task automatic send_frame(input logic [31:0] v, input int n, input logic mode, input int gp);
      for (int i = 0; i < n; i++) begin
         for (int g = 0; g < 3 && int'($urandom_range(99)) < gp; g++) begin
            bus_data_in_valid = 1'b0;
            bus_data_in = 1'($urandom);
            bus_mode = 1'($urandom);
            tick();
         end
         bus_data_in = v[i];
         bus_mode = mode;
         bus_data_in_valid = 1'b1;
         tick();
      end
      bus_data_in_valid = 1'b0;
   endtask

   task automatic send_addr(input logic [AW-1:0] a, input int gp);
      send_frame(afr(a), AW + PAR, 1'b0, gp);
   endtask

   task automatic send_data(input logic [DW-1:0] d, input int gp);
      send_frame(dfr(d), DW + PAR, 1'b1, gp);
   endtask

   task automatic expect_delivery(input string tag, input logic [AW-1:0] ea,
                                  input logic [DW-1:0] ed, input logic edv);
      tick();
      chk({tag, "_addr_valid"}, 32'(target_addr_in_valid), 1);
      chk({tag, "_addr"}, 32'(target_addr_in), 32'(ea));
      chk({tag, "_data"}, 32'(target_data_in), 32'(ed));
      chk({tag, "_data_valid"}, 32'(target_data_in_valid), 32'(edv));
      tick();
      chk({tag, "_pulse_end"}, 32'(target_addr_in_valid), 0);
      chk({tag, "_addr_held"}, 32'(target_addr_in), 32'(ea));
   endtask

   task automatic push_word(input logic [DW-1:0] w, output int acc);
      logic rdy;
      acc = -1;
      target_data_out = w;
      target_data_out_valid = 1'b1;
      for (int k = 0; k < 100 && acc < 0; k++) begin
         rdy = target_data_out_ready;
         if (!rdy) stall_seen = 1'b1;
         tick();
         if (rdy) acc = cyc;
      end
      target_data_out_valid = 1'b0;
      if (acc < 0) begin
         vec_cnt++;
         miscmp++;
         $display("FAIL push_timeout: word 0x%0h never accepted", w);
      end
   endtask

   task automatic wait_tx(input int n, input int limit);
      for (int k = 0; k < limit && txw_q.size() < n; k++) tick();
      chk("tx_word_count", 32'(txw_q.size()), 32'(n));
   endtask

   typedef struct {
      logic rw; logic [AW-1:0] addr; logic [DW-1:0] data;
      logic [AW-1:0] exp_addr; logic [DW-1:0] exp_data; logic exp_dv;
   } rx_vec_t;

   rx_vec_t vecs[5];
   logic [DW-1:0] exp_tx[$];
   logic [DW-1:0] burst[6];

   initial begin
      int acc, c0, base, n0;
      logic rw;
      logic [AW-1:0] a;
      logic [DW-1:0] d;

      vecs[0] = '{1'b0, 16'hA5C3, 8'h00, 16'hA5C3, 8'h00, 1'b0};
      vecs[1] = '{1'b1, 16'h1234, 8'h5A, 16'h1234, 8'h5A, 1'b1};
      vecs[2] = '{1'b0, 16'h8000, 8'hEE, 16'h8000, 8'h00, 1'b0};
      vecs[3] = '{1'b1, 16'hFFFF, 8'h00, 16'hFFFF, 8'h00, 1'b1};
      vecs[4] = '{1'b1, 16'h0001, 8'hFF, 16'h0001, 8'hFF, 1'b1};
      burst = '{8'h81, 8'h3C, 8'hFF, 8'h00, 8'hA7, 8'h42};

      // Reset state
      tick();
      chk("rst_ready", 32'(target_data_out_ready), 1);
      chk("rst_tx_valid", 32'(bus_data_out_valid), 0);
      chk("rst_addr_valid", 32'(target_addr_in_valid), 0);
      chk("rst_addr", 32'(target_addr_in), 0);
      chk("rst_errs", {30'd0, rx_err, parity_err}, 0);
      tick();
      rst = 1'b0;
      tick();

      // Combinational status copies
      for (int i = 0; i < 8; i++) begin
         {target_rw, target_ready, target_ack} = 3'(i);
         #1;
         chk("status_copy", {29'd0, bus_target_rw, bus_target_ready, bus_target_ack}, 32'(i));
      end

      // Directed RX table
      foreach (vecs[i]) begin
         target_rw = vecs[i].rw;
         send_addr(vecs[i].addr, 0);
         if (vecs[i].rw) begin
            target_rw = 1'b0;
            send_data(vecs[i].data, 0);
         end
         expect_delivery("table", vecs[i].exp_addr, vecs[i].exp_data, vecs[i].exp_dv);
      end

      // TX burst: 4 back-to-back pushes with ready high, then fill until stalled
      txw_q.delete(); gap_q.delete(); fb_cyc_q.delete();
      stall_seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("burst_ready", 32'(target_data_out_ready), 1);
         push_word(burst[i], acc);
         if (i == 0) c0 = acc;
      end
      push_word(burst[4], acc);
      chk("full_ready_low", 32'(target_data_out_ready), 0);
      push_word(burst[5], acc);
      chk("stall_seen", 32'(stall_seen), 1);
      wait_tx(6, 200);
      for (int i = 0; i < 6 && i < txw_q.size(); i++) begin
         chk("burst_word", 32'(txw_q[i]), dfr(burst[i]));
         if (i > 0) chk("burst_gap", 32'(gap_q[i]), 1);
      end
      if (fb_cyc_q.size() > 0) chk("first_bit_latency", 32'(fb_cyc_q[0] - c0), 2);
      chk("tx_no_break", 32'(tx_broken), 0);
      repeat (3) tick();

      // Error cases
      base = rxe_cnt; n0 = av_cnt;
      bus_mode = 1'b1; bus_data_in = 1'b1; bus_data_in_valid = 1'b1;
      tick();
      bus_data_in_valid = 1'b0;
      chk("err_data_no_pending", 32'(rx_err), 1);
      tick();
      chk("err_pulse_end", 32'(rx_err), 0);
      chk("err_no_valid", 32'(av_cnt - n0), 0);
      target_rw = 1'b0;
      send_frame(32'h1F, 5, 1'b0, 0);
      send_frame(32'h0, 1, 1'b1, 0);
      chk("err_abort_addr", 32'(rx_err), 1);
      send_addr(16'h0001, 0);
      expect_delivery("after_abort", 16'h0001, 8'h00, 1'b0);
      target_rw = 1'b1;
      send_addr(16'h0F0F, 0);
      target_rw = 1'b0;
      send_frame(32'h1, 1, 1'b0, 0);
      chk("err_addr_while_pending", 32'(rx_err), 1);
      send_data(8'h77, 0);
      expect_delivery("pending_kept", 16'h0F0F, 8'h77, 1'b1);
      chk("err_total", 32'(rxe_cnt - base), 3);

      // RX bits are ignored while TX is busy
      txw_q.delete();
      base = rxe_cnt;
      push_word(8'hC5, acc);
      repeat (3) tick();
      send_frame(32'h1, 1, 1'b1, 0);
      send_frame(32'h1, 1, 1'b0, 0);
      wait_tx(1, 50);
      repeat (2) tick();
      chk("rx_ignored_no_err", 32'(rxe_cnt - base), 0);
      send_addr(16'h00F0, 0);
      expect_delivery("after_ignore", 16'h00F0, 8'h00, 1'b0);

`ifdef SERIAL_PARITY_EN
      // Parity: bad data parity, bad address parity, TX parity bit
      base = pe_cnt; n0 = av_cnt;
      target_rw = 1'b1;
      send_addr(16'h00FF, 0);
      target_rw = 1'b0;
      send_frame({23'd0, ~^(8'h5A), 8'h5A}, DW + 1, 1'b1, 0);
      tick();
      chk("par_data_err", 32'(parity_err), 1);
      send_frame({15'd0, ~^(16'h0003), 16'h0003}, AW + 1, 1'b0, 0);
      tick();
      chk("par_addr_err", 32'(parity_err), 1);
      tick();
      chk("par_no_valid", 32'(av_cnt - n0), 0);
      chk("par_err_count", 32'(pe_cnt - base), 2);
      send_data(8'h11, 0);
      chk("par_pending_dropped", 32'(rx_err), 1);
      txw_q.delete();
      push_word(8'h07, acc);
      wait_tx(1, 50);
      if (txw_q.size() > 0) chk("par_tx_word", 32'(txw_q[0]), 32'h107);
      repeat (2) tick();
`endif

      // Randomised RX transactions against the model
      for (int t = 0; t < 30; t++) begin
         rw = 1'($urandom);
         a = AW'($urandom);
         d = DW'($urandom);
         target_rw = rw;
         send_addr(a, 30);
         if (rw) begin
            target_rw = 1'($urandom);
            repeat ($urandom_range(2)) tick();
            send_data(d, 30);
         end
         expect_delivery("rand_rx", a, rw ? d : '0, rw);
      end

      // Randomised TX stream against the model queue
      txw_q.delete();
      exp_tx.delete();
      for (int t = 0; t < 16; t++) begin
         repeat ($urandom_range(3)) tick();
         d = DW'($urandom);
         push_word(d, acc);
         exp_tx.push_back(d);
      end
      wait_tx(16, 1000);
      for (int i = 0; i < 16 && i < txw_q.size(); i++) chk("rand_tx", 32'(txw_q[i]), dfr(exp_tx[i]));
      chk("rand_tx_no_break", 32'(tx_broken), 0);

      // Reset mid-address and mid-TX
      txw_q.delete();
      target_rw = 1'b0;
      send_frame(32'h7F, 7, 1'b0, 0);
      push_word(8'h5A, acc);
      push_word(8'h6B, acc);
      repeat (4) tick();
      rst = 1'b1;
      #1;
      chk("mid_rst_tx_valid", 32'(bus_data_out_valid), 0);
      chk("mid_rst_ready", 32'(target_data_out_ready), 1);
      chk("mid_rst_addr", 32'(target_addr_in), 0);
      chk("mid_rst_data", 32'(target_data_in), 0);
      tick();
      rst = 1'b0;
      n0 = txw_q.size();
      repeat (25) tick();
      chk("mid_rst_fifo_flushed", 32'(txw_q.size()), 32'(n0));
      send_addr(16'h8000, 0);
      expect_delivery("post_rst", 16'h8000, 8'h00, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: bench did not complete");
      $fatal(1);
   end
endmodule
